lfsr8b_checker: RTL and testbench

- Receive-side companion to the team's 8-bit test-pattern LFSR generator.
- Consumes a byte stream produced by that generator, for example after it passes through the AES encrypt/decrypt loop.
- Self-synchronises to the sequence, declares lock, and then flags and counts every byte that deviates from the predicted sequence.
- Used in testbenches and on-chip loopback to prove the datapath is bit-exact.

---
 rtl/lfsr8b_checker.sv | 131 +++++++++++++
 tb/tb_lfsr8b_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr8b_checker.sv
// Receive-side checker for the 8-bit test-pattern LFSR stream.
// It hunts for the sequence, verifies it, and locks on. Once locked it flywheels and counts deviations.
module lfsr8b_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] byte_count,
  output logic [7:0]       expected
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] match_q, match_d;
  logic [3:0] miss_q, miss_d;
  logic [7:0] exp_d;
  logic       err_d;
  logic       bump_bytes;
  logic       bump_err;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    exp_d      = expected;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    bump_bytes = 1'b0;
    bump_err   = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_data != 8'h00) begin
            exp_d   = step8(in_data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected) begin
            match_d = match_q + 4'd1;
            exp_d   = step8(in_data);
            if (match_d == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (in_data != 8'h00) begin
            exp_d   = step8(in_data);
            match_d = '0;
          end else begin
            state_d = HUNT;
            match_d = '0;
          end
        end
        LOCKED: begin
          // The prediction flywheels from its own value, so isolated corrupt bytes do not cause a resync.
          exp_d      = step8(expected);
          bump_bytes = 1'b1;
          if (in_data == expected) begin
            miss_d = '0;
          end else begin
            err_d    = 1'b1;
            bump_err = 1'b1;
            miss_d   = miss_q + 4'd1;
            if (miss_d == LOSS_N) begin
              state_d = HUNT;
              miss_d  = '0;
              match_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      match_q  <= '0;
      miss_q   <= '0;
      expected <= 8'h00;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      expected <= exp_d;
      locked   <= (state_d == LOCKED);
      err      <= err_d;
    end
  end

  // A clear wins over a same-cycle increment. Both counters hold at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      byte_count <= '0;
    end else if (clear_counts) begin
      err_count  <= '0;
      byte_count <= '0;
    end else begin
      if (bump_err && err_count != CNT_MAX)
        err_count <= err_count + 1'b1;
      if (bump_bytes && byte_count != CNT_MAX)
        byte_count <= byte_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr8b_checker.sv
// Directed bench for lfsr8b_checker: lock, flywheel errors, loss of lock, hunt edge cases,
// counter saturation, clear priority and asynchronous reset.
module tb_lfsr8b_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             clear_counts;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       expected;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr8b_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clear_counts (clear_counts),
    .locked       (locked),
    .err          (err),
    .err_count    (err_count),
    .byte_count   (byte_count),
    .expected     (expected)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the response visible.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  logic [7:0] exp_m;
  int         ec_m;
  int         bc_m;

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    clear_counts = 1'b0;
    #1;
    check("rst_locked", 16'(locked), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_err_count", 16'(err_count), 16'h0);
    check("rst_byte_count", 16'(byte_count), 16'h0);
    check("rst_expected", 16'(expected), 16'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Acquire lock on 01,80,40,20,10
    send(8'h01);
    check("seed_expected", 16'(expected), 16'h80);
    check("seed_locked", 16'(locked), 16'h0);
    send(8'h80);
    send(8'h40);
    send(8'h20);
    check("verify3_locked", 16'(locked), 16'h0);
    send(8'h10);
    check("lock_locked", 16'(locked), 16'h1);
    check("lock_expected", 16'(expected), 16'h88);
    check("lock_err_count", 16'(err_count), 16'h0);
    check("lock_byte_count", 16'(byte_count), 16'h0);

    // Single corrupted byte: flywheel keeps prediction, one err pulse
    send(8'h55);
    check("bad1_err", 16'(err), 16'h1);
    check("bad1_err_count", 16'(err_count), 16'h1);
    check("bad1_expected", 16'(expected), 16'hC4);
    @(negedge clk);
    check("bad1_err_pulse", 16'(err), 16'h0);
    send(8'hC4);
    check("c4_expected", 16'(expected), 16'hE2);
    check("c4_err", 16'(err), 16'h0);
    send(8'hE2);
    check("e2_expected", 16'(expected), 16'h71);
    check("e2_locked", 16'(locked), 16'h1);
    send(8'h71);
    send(8'h38);
    check("good_byte_count", 16'(byte_count), 16'h5);
    check("good_err_count", 16'(err_count), 16'h1);
    check("good_expected", 16'(expected), 16'h1C);

    // Three consecutive misses drop lock
    send(8'hAA);
    check("loss1_err", 16'(err), 16'h1);
    check("loss1_locked", 16'(locked), 16'h1);
    send(8'hAA);
    check("loss2_err", 16'(err), 16'h1);
    check("loss2_locked", 16'(locked), 16'h1);
    send(8'hAA);
    check("loss3_err", 16'(err), 16'h1);
    check("loss3_locked", 16'(locked), 16'h0);
    check("loss3_err_count", 16'(err_count), 16'h4);
    check("loss3_byte_count", 16'(byte_count), 16'h8);
    check("loss3_expected", 16'(expected), 16'h23);

    // HUNT ignores zeros; counters frozen outside LOCKED
    send(8'h00);
    send(8'h00);
    check("hunt_zero_expected", 16'(expected), 16'h23);
    check("hunt_zero_locked", 16'(locked), 16'h0);
    send(8'h01);
    send(8'h80);
    check("verify_expected", 16'(expected), 16'h40);
    send(8'h00);
    check("verify_zero_locked", 16'(locked), 16'h0);
    check("verify_zero_err", 16'(err), 16'h0);

    // Reseed on FF, must need four fresh matches (gaps allowed)
    send(8'h01);
    send(8'h80);
    send(8'hFF);
    check("reseed_expected", 16'(expected), 16'h7F);
    check("reseed_err", 16'(err), 16'h0);
    send(8'h7F);
    repeat (3) @(negedge clk);
    check("gap_expected", 16'(expected), 16'h3F);
    send(8'h3F);
    send(8'h1F);
    check("reseed_m3_locked", 16'(locked), 16'h0);
    send(8'h0F);
    check("relock_locked", 16'(locked), 16'h1);
    check("relock_expected", 16'(expected), 16'h87);
    check("relock_err_count", 16'(err_count), 16'h4);
    check("relock_byte_count", 16'(byte_count), 16'h8);

    // 20 mismatches interleaved with matches so lock holds; counters saturate
    exp_m = 8'h87;
    ec_m  = 4;
    bc_m  = 8;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 2; j++) begin
        send(exp_m ^ 8'h5A);
        exp_m = lfsr_next(exp_m);
        ec_m  = (ec_m < 15) ? ec_m + 1 : 15;
        bc_m  = (bc_m < 15) ? bc_m + 1 : 15;
        check("sat_err", 16'(err), 16'h1);
        check("sat_err_count", 16'(err_count), 16'(ec_m));
      end
      send(exp_m);
      exp_m = lfsr_next(exp_m);
      bc_m  = (bc_m < 15) ? bc_m + 1 : 15;
      check("sat_locked", 16'(locked), 16'h1);
      check("sat_byte_count", 16'(byte_count), 16'(bc_m));
    end
    check("sat_err_count_final", 16'(err_count), 16'hF);
    check("sat_expected", 16'(expected), 16'(exp_m));

    // Clear beats a simultaneous mismatch increment; err still pulses
    clear_counts = 1'b1;
    send(exp_m ^ 8'hFF);
    clear_counts = 1'b0;
    exp_m = lfsr_next(exp_m);
    check("clr_err_count", 16'(err_count), 16'h0);
    check("clr_byte_count", 16'(byte_count), 16'h0);
    check("clr_err", 16'(err), 16'h1);
    check("clr_locked", 16'(locked), 16'h1);
    check("clr_expected", 16'(expected), 16'(exp_m));
    send(exp_m);
    exp_m = lfsr_next(exp_m);
    check("post_clr_byte_count", 16'(byte_count), 16'h1);
    check("post_clr_err_count", 16'(err_count), 16'h0);

    // Asynchronous reset mid-stream, between clock edges
    in_valid = 1'b1;
    in_data  = exp_m;
    #2;
    reset = 1'b1;
    #1;
    check("arst_locked", 16'(locked), 16'h0);
    check("arst_err", 16'(err), 16'h0);
    check("arst_err_count", 16'(err_count), 16'h0);
    check("arst_byte_count", 16'(byte_count), 16'h0);
    check("arst_expected", 16'(expected), 16'h00);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("arst_hold_locked", 16'(locked), 16'h0);
    check("arst_hold_expected", 16'(expected), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
